sirv_gnrl_skidbuf: RTL and testbench
====================================

// Module: sirv_gnrl_skidbuf
// PURPOSE
//  Two-entry valid/ready skid buffer: the consumer-side counterpart of the load-enabled DFF stages.
//  Accepts a producer stream (i_*), presents it to a consumer (o_*) with registered ready and data.
//  Cuts the combinational ready path between pipeline stages at full throughput.
//  Used between GPGPU pipeline stages wherever a DFF stage must tolerate back-pressure.
// PARAMETERS
//  DW      32   payload width in bits
//  CNT_W   16   stall counter width (used only with SIRV_GNRL_SKIDBUF_STALL_CNT_EN)
// PORTS
//  clk           in   1      clock, rising edge
//  rst           in   1      asynchronous, active-high reset
//  i_vld         in   1      producer data valid
//  i_rdy         out  1      buffer can accept; registered (= ~skid_vld)
//  i_dat         in   DW     producer payload
//  o_vld         out  1      payload valid to consumer; registered (= main_vld)
//  o_rdy         in   1      consumer accepts
//  o_dat         out  DW     payload to consumer; driven from the main register
//  o_stall_cnt   out  CNT_W  saturating stall count (port exists only with the macro)
// BEHAVIOUR
//  - Reset (async assert, sync-safe release): state=EMPTY, o_vld=0, i_rdy=1, main/skid data=0, stall cnt=0.
//  - Handshake: a transfer occurs on a clock edge where vld&rdy; once o_vld=1, o_dat is held until o_rdy.
//  - States (main_vld, skid_vld): EMPTY(0,0), ONE(1,0), FULL(1,1); (0,1) is unreachable.
//  - EMPTY: i_vld -> main<=i_dat, ONE. Else stay.
//  - ONE: i_vld&o_rdy -> main<=i_dat, stay ONE (back-to-back, 1 word/cycle).
//         i_vld&~o_rdy -> skid<=i_dat, FULL. ~i_vld&o_rdy -> EMPTY. ~i_vld&~o_rdy -> hold.
//  - FULL: i_rdy=0, i_dat ignored. o_rdy -> main<=skid, ONE. Else hold both.
//  - Latency: word accepted at edge N is visible on o_dat after edge N (o_vld=1 in cycle N+1).
//  - Ordering strictly FIFO; no drop, no duplication; i_dat is sampled only on an accept.
//  - i_rdy depends only on state, never combinationally on o_rdy or i_vld.
//  - rst asserted mid-transfer: both entries are discarded immediately; o_vld falls asynchronously.
//  - Data registers use load-enable only; no other register updates without a handshake.
// CONFIGURATION
//  SIRV_GNRL_SKIDBUF_STALL_CNT_EN defined: adds o_stall_cnt; increments by 1 on each cycle with
//   o_vld&~o_rdy, saturates at all-ones, cleared only by rst.
//  Not defined: port and counter absent; behaviour otherwise identical.
// STRUCTURE
//  Shared package sirv_gnrl_pkg: skidbuf state encoding localparams
//   (SKB_EMPTY=2'b00, SKB_ONE=2'b01, SKB_FULL=2'b11).
//  One sub-module sirv_gnrl_skidbuf_ent: DW-wide load-enabled entry register with async reset to 0,
//   instantiated twice (main, skid). The control FSM stays in the top module.
// TESTING
//  1. Reset: rst=1 -> o_vld=0, i_rdy=1, o_dat=0; mid-FULL reset -> EMPTY next observation.
//  2. Streaming: i_vld=1 with 0x1,0x2,0x3..., o_rdy=1 -> o_dat 0x1,0x2,0x3 one per cycle, i_rdy stays 1.
//  3. Stall: push 0xA, 0xB with o_rdy=0 -> FULL, i_rdy=0, o_dat=0xA held; o_rdy=1 -> 0xA then 0xB.
//  4. Ignore-when-full: in FULL drive i_vld=1, i_dat=0xDEAD -> never appears on o_dat.
//  5. Random vld/rdy 10k cycles vs. scoreboard queue -> in-order, lossless; i_rdy never combinational.
//  6. STALL_CNT_EN: hold o_vld=1, o_rdy=0 for 5 cycles -> o_stall_cnt=5; CNT_W=2 -> saturates at 3.

Source files
------------

// File: rtl/sirv_gnrl_pkg.sv
// rtl/sirv_gnrl_pkg.sv - shared encodings for the sirv_gnrl pipeline helpers
//
// Skid buffer state is the pair {skid_vld, main_vld}, so o_vld and i_rdy are
// read straight off the state register bits:
//   SKB_EMPTY = 2'b00 : nothing held
//   SKB_ONE   = 2'b01 : main register valid
//   SKB_FULL  = 2'b11 : main and skid registers valid
// 2'b10 is unreachable.
package sirv_gnrl_pkg;

    localparam logic [1:0] SKB_EMPTY = 2'b00;
    localparam logic [1:0] SKB_ONE   = 2'b01;
    localparam logic [1:0] SKB_FULL  = 2'b11;

    // Bit positions inside the state word.
    localparam int SKB_MAIN_BIT = 0;
    localparam int SKB_SKID_BIT = 1;

endpackage

// File: rtl/sirv_gnrl_skidbuf_if.sv
// rtl/sirv_gnrl_skidbuf_if.sv - producer/consumer handshake bundle for the skid buffer
//
// Signals:
//   i_vld / i_rdy / i_dat : producer side (into the buffer)
//   o_vld / o_rdy / o_dat : consumer side (out of the buffer)
// Modports:
//   slave  : the buffer's view (accepts i_*, drives o_*)
//   master : the surrounding logic's view (drives i_*, o_rdy)
interface sirv_gnrl_skidbuf_if #(
    parameter int DW = 32
);

    logic          i_vld;
    logic          i_rdy;
    logic [DW-1:0] i_dat;
    logic          o_vld;
    logic          o_rdy;
    logic [DW-1:0] o_dat;

    modport slave (
        input  i_vld,
        output i_rdy,
        input  i_dat,
        output o_vld,
        input  o_rdy,
        output o_dat
    );

    modport master (
        output i_vld,
        input  i_rdy,
        output i_dat,
        input  o_vld,
        output o_rdy,
        input  o_dat
    );

endinterface

// File: rtl/sirv_gnrl_skidbuf_ent.sv
// rtl/sirv_gnrl_skidbuf_ent.sv - DW-wide load-enabled entry register
//
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset, clears q to 0
//   ld  : load enable; q captures d only when set
//   d   : next value
//   q   : stored value
module sirv_gnrl_skidbuf_ent #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/sirv_gnrl_skidbuf.sv
// rtl/sirv_gnrl_skidbuf.sv - two-entry valid/ready skid buffer with registered ready
//
// Breaks the combinational ready path between pipeline stages while still
// moving one word per cycle. The main entry always feeds the consumer; the
// skid entry catches the one word that arrives in the cycle the consumer
// stalls. i_rdy and o_vld come straight from state flops.
//
// Ports:
//   clk         : clock, rising edge
//   rst         : asynchronous active-high reset
//   bus         : sirv_gnrl_skidbuf_if.slave (i_vld/i_rdy/i_dat, o_vld/o_rdy/o_dat)
//   o_stall_cnt : saturating count of o_vld & ~o_rdy cycles
//                 (present only when SIRV_GNRL_SKIDBUF_STALL_CNT_EN is defined)
//
// Build option: SIRV_GNRL_SKIDBUF_STALL_CNT_EN adds the stall counter.
module sirv_gnrl_skidbuf
    import sirv_gnrl_pkg::*;
#(
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    sirv_gnrl_skidbuf_if.slave   bus
`ifdef SIRV_GNRL_SKIDBUF_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]     o_stall_cnt
`endif
);

    logic [1:0]    state_q;
    logic [1:0]    state_d;

    logic          main_ld;
    logic          main_sel_skid;
    logic          skid_ld;
    logic [DW-1:0] main_d;
    logic [DW-1:0] main_q;
    logic [DW-1:0] skid_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SKB_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SKB_EMPTY: begin
                if (bus.i_vld) begin
                    state_d = SKB_ONE;
                end
            end
            SKB_ONE: begin
                if (bus.i_vld && !bus.o_rdy) begin
                    state_d = SKB_FULL;
                end else if (!bus.i_vld && bus.o_rdy) begin
                    state_d = SKB_EMPTY;
                end
            end
            SKB_FULL: begin
                if (bus.o_rdy) begin
                    state_d = SKB_ONE;
                end
            end
            default: begin
                // The unreachable encoding recovers to a clean empty buffer.
                state_d = SKB_EMPTY;
            end
        endcase
    end

    // Output / load-enable logic.
    always_comb begin
        main_ld       = 1'b0;
        main_sel_skid = 1'b0;
        skid_ld       = 1'b0;
        case (state_q)
            SKB_EMPTY: begin
                main_ld = bus.i_vld;
            end
            SKB_ONE: begin
                // Consumer taking the word frees main for the incoming one;
                // otherwise the incoming word parks in skid.
                main_ld = bus.i_vld && bus.o_rdy;
                skid_ld = bus.i_vld && !bus.o_rdy;
            end
            SKB_FULL: begin
                // Producer is blocked here, so i_dat is never sampled.
                main_ld       = bus.o_rdy;
                main_sel_skid = 1'b1;
            end
            default: begin
                main_ld = 1'b0;
            end
        endcase
    end

    assign main_d = main_sel_skid ? skid_q : bus.i_dat;

    sirv_gnrl_skidbuf_ent #(.DW(DW)) u_main (
        .clk (clk),
        .rst (rst),
        .ld  (main_ld),
        .d   (main_d),
        .q   (main_q)
    );

    sirv_gnrl_skidbuf_ent #(.DW(DW)) u_skid (
        .clk (clk),
        .rst (rst),
        .ld  (skid_ld),
        .d   (bus.i_dat),
        .q   (skid_q)
    );

    assign bus.o_vld = state_q[SKB_MAIN_BIT];
    assign bus.i_rdy = ~state_q[SKB_SKID_BIT];
    assign bus.o_dat = main_q;

`ifdef SIRV_GNRL_SKIDBUF_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (bus.o_vld && !bus.o_rdy && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sirv_gnrl_skidbuf.sv
// tb/tb_sirv_gnrl_skidbuf.sv - self-checking bench for sirv_gnrl_skidbuf
module tb_sirv_gnrl_skidbuf;

    localparam int DW = 32;

    logic clk;
    logic rst;

    int n_tests;
    int n_fail;

    logic [DW-1:0] sb_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sirv_gnrl_skidbuf_if #(.DW(DW)) bus ();

`ifdef SIRV_GNRL_SKIDBUF_STALL_CNT_EN
    logic [15:0] stall_cnt;
    logic [1:0]  stall_cnt2;

    // Second instance with a 2-bit counter, fed the same stimulus.
    sirv_gnrl_skidbuf_if #(.DW(DW)) bus2 ();
    assign bus2.i_vld = bus.i_vld;
    assign bus2.i_dat = bus.i_dat;
    assign bus2.o_rdy = bus.o_rdy;

    sirv_gnrl_skidbuf #(.DW(DW), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_stall_cnt (stall_cnt)
    );

    sirv_gnrl_skidbuf #(.DW(DW), .CNT_W(2)) dut2 (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus2),
        .o_stall_cnt (stall_cnt2)
    );
`else
    sirv_gnrl_skidbuf #(.DW(DW), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [DW-1:0] dat, input logic rdy);
        bus.i_vld = vld;
        bus.i_dat = dat;
        bus.o_rdy = rdy;
    endtask

    initial begin
        logic          iv;
        logic          orr;
        logic [DW-1:0] id;
        bit            in_acc;
        bit            out_acc;

        n_tests = 0;
        n_fail  = 0;

        // Reset state.
        rst = 1'b1;
        drive(1'b0, '0, 1'b0);
        tick();
        check("rst_o_vld", 64'(bus.o_vld), 64'd0);
        check("rst_i_rdy", 64'(bus.i_rdy), 64'd1);
        check("rst_o_dat", 64'(bus.o_dat), 64'd0);
        rst = 1'b0;
        tick();

        // Streaming: one word per cycle with the consumer always ready.
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, DW'(k), 1'b1);
            tick();
            check("stream_o_vld", 64'(bus.o_vld), 64'd1);
            check("stream_o_dat", 64'(bus.o_dat), 64'(k));
            check("stream_i_rdy", 64'(bus.i_rdy), 64'd1);
        end
        drive(1'b0, '0, 1'b1);
        tick();
        check("stream_drain_o_vld", 64'(bus.o_vld), 64'd0);

        // Stall: two words with the consumer blocked fill the buffer.
        drive(1'b1, 32'hA, 1'b0);
        tick();
        check("stall_one_o_dat", 64'(bus.o_dat), 64'hA);
        check("stall_one_i_rdy", 64'(bus.i_rdy), 64'd1);
        drive(1'b1, 32'hB, 1'b0);
        tick();
        check("stall_full_i_rdy", 64'(bus.i_rdy), 64'd0);
        check("stall_full_o_dat", 64'(bus.o_dat), 64'hA);
        check("stall_full_o_vld", 64'(bus.o_vld), 64'd1);

        // Full: producer word must be ignored, with and without a drain.
        drive(1'b1, 32'hDEAD, 1'b0);
        tick();
        check("full_hold_o_dat", 64'(bus.o_dat), 64'hA);
        check("full_hold_i_rdy", 64'(bus.i_rdy), 64'd0);
        drive(1'b1, 32'hDEAD, 1'b1);
        #1;
        check("full_i_rdy_not_comb", 64'(bus.i_rdy), 64'd0);
        tick();
        check("drain1_o_dat", 64'(bus.o_dat), 64'hB);
        check("drain1_i_rdy", 64'(bus.i_rdy), 64'd1);
        drive(1'b0, 32'hDEAD, 1'b1);
        tick();
        check("drain2_o_vld", 64'(bus.o_vld), 64'd0);

        // Reset asserted while full discards both entries asynchronously.
        drive(1'b1, 32'h11, 1'b0);
        tick();
        drive(1'b1, 32'h22, 1'b0);
        tick();
        check("pre_rst_i_rdy", 64'(bus.i_rdy), 64'd0);
        drive(1'b0, '0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_o_vld", 64'(bus.o_vld), 64'd0);
        check("async_rst_i_rdy", 64'(bus.i_rdy), 64'd1);
        check("async_rst_o_dat", 64'(bus.o_dat), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post_rst_o_vld", 64'(bus.o_vld), 64'd0);
        bus.o_rdy = 1'b1;
        tick();
        check("post_rst_o_vld2", 64'(bus.o_vld), 64'd0);

        // Random traffic against a queue scoreboard.
        sb_q.delete();
        for (int c = 0; c < 10000; c++) begin
            iv  = ($urandom_range(0, 3) != 0);
            orr = ($urandom_range(0, 2) != 0);
            id  = $urandom;
            drive(iv, id, orr);
            #1;
            check("rnd_o_vld", 64'(bus.o_vld), 64'(sb_q.size() > 0));
            check("rnd_i_rdy", 64'(bus.i_rdy), 64'(sb_q.size() < 2));
            if (sb_q.size() > 0) begin
                check("rnd_o_dat", 64'(bus.o_dat), 64'(sb_q[0]));
            end
            in_acc  = iv && (sb_q.size() < 2);
            out_acc = orr && (sb_q.size() > 0);
            tick();
            if (out_acc) begin
                void'(sb_q.pop_front());
            end
            if (in_acc) begin
                sb_q.push_back(id);
            end
        end

`ifdef SIRV_GNRL_SKIDBUF_STALL_CNT_EN
        // Stall counter: five blocked cycles, 2-bit copy saturates at 3.
        rst = 1'b1;
        drive(1'b0, '0, 1'b0);
        tick();
        rst = 1'b0;
        check("cnt_rst", 64'(stall_cnt), 64'd0);
        drive(1'b1, 32'h5, 1'b0);
        tick();
        check("cnt_first", 64'(stall_cnt), 64'd0);
        drive(1'b0, '0, 1'b0);
        repeat (5) tick();
        check("cnt_16b", 64'(stall_cnt), 64'd5);
        check("cnt_2b_sat", 64'(stall_cnt2), 64'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
